// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared types and S-box tables for the ASCON substitution layer
//
// Purpose : 320-bit state type, FSM state enum, forward and inverse 5-bit
//           ASCON S-box lookup tables.
// Ports   : none (package).
package ascon_pack;

  // x0 occupies the most significant 64 bits of the flat 320-bit vector.
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } type_fsm;

  localparam logic [4:0] SBOX_C [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  localparam logic [4:0] SBOX_INV_C [32] = '{
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };

endpackage

// File: rtl/sbox5.sv
// rtl/sbox5.sv - combinational 5-bit ASCON S-box
//
// Purpose : one bit-slice lookup; inverse table selectable when
//           ASCON_SBOX_INV_EN is defined.
// Ports   : i_x   in  5  slice {x0,x1,x2,x3,x4}, x0 is the MSB
//           o_y   out 5  substituted slice, same bit order
//           i_inv in  1  select inverse table (only with ASCON_SBOX_INV_EN)
module sbox5
  import ascon_pack::*;
(
  input  logic [4:0] i_x,
`ifdef ASCON_SBOX_INV_EN
  input  logic       i_inv,
`endif
  output logic [4:0] o_y
);

`ifdef ASCON_SBOX_INV_EN
  assign o_y = i_inv ? SBOX_INV_C[i_x] : SBOX_C[i_x];
`else
  assign o_y = SBOX_C[i_x];
`endif

endmodule

// File: rtl/substitution_iter.sv
// rtl/substitution_iter.sv - iterative ASCON substitution layer, LANES slices per clock
//
// Purpose : applies the ASCON S-box to all 64 bit-slices of a 320-bit state,
//           LANES slices per cycle, over NSTEP = 64/LANES cycles.
//           Optional macro ASCON_SBOX_INV_EN adds inv_i (inverse S-box mode).
// Ports   : clock_i in  1    rising-edge clock
//           reset_i in  1    synchronous active-high reset
//           valid_i in  1    state_i valid
//           ready_o out 1    block can accept state_i
//           state_i in  320  input state
//           valid_o out 1    state_o holds a completed result
//           ready_i in  1    downstream accepts state_o
//           state_o out 320  substituted state (registered)
//           busy_o  out 1    substitution in progress
//           inv_i   in  1    inverse mode, sampled at load (ASCON_SBOX_INV_EN only)
module substitution_iter
  import ascon_pack::*;
#(
  parameter int LANES = 8
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      valid_i,
  output logic      ready_o,
  input  type_state state_i,
  output logic      valid_o,
  input  logic      ready_i,
  output type_state state_o,
`ifdef ASCON_SBOX_INV_EN
  input  logic      inv_i,
`endif
  output logic      busy_o
);

  localparam int NSTEP = 64 / LANES;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int LW    = $clog2(LANES);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
      LANES != 16 && LANES != 32 && LANES != 64) begin : g_bad_lanes
    $error("substitution_iter: LANES must be one of 1,2,4,8,16,32,64");
  end

  type_fsm       r_fsm;
  type_fsm       w_fsm_nxt;
  logic [CW-1:0] r_cnt;
  type_state     r_data;
  type_state     w_data_upd;
  logic          w_load;
  logic          w_last;
  logic [5:0]    w_base;
  logic [4:0]    w_sin  [LANES];
  logic [4:0]    w_sout [LANES];

`ifdef ASCON_SBOX_INV_EN
  logic          r_inv;
`endif

  // LANES is a power of two, so the slice base is the count shifted up.
  assign w_base = 6'(r_cnt) << LW;
  assign w_last = (r_cnt == CW'(NSTEP - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [5:0] w_idx;
    assign w_idx    = w_base + 6'(l);
    assign w_sin[l] = {r_data.x0[w_idx], r_data.x1[w_idx], r_data.x2[w_idx],
                       r_data.x3[w_idx], r_data.x4[w_idx]};
    sbox5 u_sbox (
      .i_x   (w_sin[l]),
`ifdef ASCON_SBOX_INV_EN
      .i_inv (r_inv),
`endif
      .o_y   (w_sout[l])
    );
  end

  // Write the substituted slices back over the active window.
  always_comb begin
    w_data_upd = r_data;
    for (int l = 0; l < LANES; l++) begin
      {w_data_upd.x0[w_base + 6'(l)], w_data_upd.x1[w_base + 6'(l)],
       w_data_upd.x2[w_base + 6'(l)], w_data_upd.x3[w_base + 6'(l)],
       w_data_upd.x4[w_base + 6'(l)]} = w_sout[l];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    busy_o    = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) w_fsm_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (w_last) w_fsm_nxt = ST_DONE;
      end
      ST_DONE: begin
        valid_o = 1'b1;
        // Accepting a new state is only possible in the same edge the result leaves.
        ready_o = ready_i;
        if (ready_i) w_fsm_nxt = valid_i ? ST_RUN : ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  assign w_load = valid_i && ready_o;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_cnt  <= '0;
      r_data <= '0;
`ifdef ASCON_SBOX_INV_EN
      r_inv  <= 1'b0;
`endif
    end else if (w_load) begin
      r_cnt  <= '0;
      r_data <= state_i;
`ifdef ASCON_SBOX_INV_EN
      r_inv  <= inv_i;
`endif
    end else if (r_fsm == ST_RUN) begin
      r_data <= w_data_upd;
      // Return to zero on the last step so the count never exceeds NSTEP-1.
      r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  assign state_o = r_data;

endmodule
